// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the block-transfer (LDM/STM) sequencer.
package arm_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_W      = 4;
   localparam int WORD_BYTES = 4;
   localparam int NUM_REGS   = 16;
   localparam int COUNT_W    = $clog2(NUM_REGS + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      WB    = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Byte span covered by n word transfers, modulo the address width.
   function automatic logic [DATA_W-1:0] block_span(input logic [COUNT_W-1:0] n);
      return DATA_W'(n) * DATA_W'(WORD_BYTES);
   endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Memory port plus register-file ports owned by the sequencer while it is busy.
interface ldm_stm_sequencer_if #(
   parameter int DATA_W = arm_pkg::DATA_W,
   parameter int REG_W  = arm_pkg::REG_W
) ();

   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic [REG_W-1:0]  rf_read_reg;
   logic [DATA_W-1:0] rf_read_data;
   logic [REG_W-1:0]  rf_write_reg;
   logic [DATA_W-1:0] rf_write_data;
   logic              rf_regwrite;

   // Sequencer side: drives requests and register-file selects.
   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output rf_read_reg,
      input  rf_read_data,
      output rf_write_reg, rf_write_data, rf_regwrite
   );

   // Memory / register-file side.
   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  rf_read_reg,
      output rf_read_data,
      input  rf_write_reg, rf_write_data, rf_regwrite
   );

endinterface

// File: rtl/ldm_stm_sequencer_reg_list_scan.sv
// Register-list scanner: lowest set bit (with valid flag) and population count.
module reg_list_scan
   import arm_pkg::*;
(
   input  logic [NUM_REGS-1:0] list_i,
   output logic [REG_W-1:0]    first_o,
   output logic                valid_o,
   output logic [COUNT_W-1:0]  count_o
);

   // Walk from the top down so the lowest set bit is the last one to win.
   always_comb begin
      first_o = '0;
      valid_o = 1'b0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (list_i[i]) begin
            first_o = REG_W'(i);
            valid_o = 1'b1;
         end
      end
   end

   // Number of registers still selected in the list.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         count_o = count_o + COUNT_W'(list_i[i]);
      end
   end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list low to high,
// one register per memory beat, then optionally writes back the base.
module ldm_stm_sequencer #(
   parameter int DATA_W = arm_pkg::DATA_W,
   parameter int REG_W  = arm_pkg::REG_W
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          is_load,
   input  logic                          up,
   input  logic                          pre,
   input  logic                          writeback,
   input  logic [arm_pkg::NUM_REGS-1:0]  reg_list,
   input  logic [REG_W-1:0]              base_reg,
   input  logic [DATA_W-1:0]             base_addr,
   output logic                          busy,
   output logic                          done,
   ldm_stm_sequencer_if.master           bus
);

   import arm_pkg::*;

   state_t                state_q, state_d;

   logic                  is_load_q;
   logic                  up_q;
   logic                  pre_q;
   logic                  writeback_q;
   logic [NUM_REGS-1:0]   list_q;      // original list, needed for the WB decision
   logic [NUM_REGS-1:0]   remain_q;    // registers not yet transferred
   logic [REG_W-1:0]      base_reg_q;
   logic [DATA_W-1:0]     base_q;
   logic [DATA_W-1:0]     addr_q;      // address of the current beat
   logic [DATA_W-1:0]     final_q;     // base value written back in WB

   logic [REG_W-1:0]      cur_idx;
   logic                  cur_valid;
   logic [COUNT_W-1:0]    remain_cnt;
   logic [NUM_REGS-1:0]   remain_after;
   logic [DATA_W-1:0]     span;
   logic [DATA_W-1:0]     start_addr;
   logic [DATA_W-1:0]     final_base;
   logic                  wb_enable;

   reg_list_scan u_scan (
      .list_i  (remain_q),
      .first_o (cur_idx),
      .valid_o (cur_valid),
      .count_o (remain_cnt)
   );

   // Remaining list once the current beat is acknowledged.
   assign remain_after = remain_q & ~(NUM_REGS'(1) << cur_idx);

   // In SETUP remain_q still holds the full list, so remain_cnt is N.
   assign span = block_span(remain_cnt);

   // Lowest address of the block; beats always ascend from here.
   always_comb begin
      start_addr = base_q;
      case ({up_q, pre_q})
         2'b10:   start_addr = base_q;                                   // IA
         2'b11:   start_addr = base_q + DATA_W'(WORD_BYTES);             // IB
         2'b00:   start_addr = base_q - span + DATA_W'(WORD_BYTES);      // DA
         default: start_addr = base_q - span;                            // DB
      endcase
   end

   assign final_base = up_q ? (base_q + span) : (base_q - span);

   // A load that includes the base register keeps the loaded value.
   assign wb_enable = writeback_q && !(is_load_q && list_q[base_reg_q]);

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = (remain_cnt == '0) ? DONE : XFER;
         end
         XFER: begin
            if (!cur_valid || (bus.mem_ack && (remain_after == '0))) begin
               state_d = WB;
            end
         end
         WB:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture, address setup and per-beat list/address advance.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         is_load_q   <= 1'b0;
         up_q        <= 1'b0;
         pre_q       <= 1'b0;
         writeback_q <= 1'b0;
         list_q      <= '0;
         remain_q    <= '0;
         base_reg_q  <= '0;
         base_q      <= '0;
         addr_q      <= '0;
         final_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  is_load_q   <= is_load;
                  up_q        <= up;
                  pre_q       <= pre;
                  writeback_q <= writeback;
                  list_q      <= reg_list;
                  remain_q    <= reg_list;
                  base_reg_q  <= base_reg;
                  base_q      <= base_addr;
               end
            end
            SETUP: begin
               addr_q  <= start_addr;
               final_q <= final_base;
            end
            XFER: begin
               if (bus.mem_ack) begin
                  remain_q <= remain_after;
                  addr_q   <= addr_q + DATA_W'(WORD_BYTES);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; beat data paths are combinational.
   always_comb begin
      busy              = 1'b0;
      done              = 1'b0;
      bus.mem_req       = 1'b0;
      bus.mem_we        = 1'b0;
      bus.mem_addr      = '0;
      bus.mem_wdata     = '0;
      bus.rf_read_reg   = '0;
      bus.rf_regwrite   = 1'b0;
      bus.rf_write_reg  = '0;
      bus.rf_write_data = '0;
      case (state_q)
         SETUP: begin
            busy = 1'b1;
         end
         XFER: begin
            busy         = 1'b1;
            bus.mem_req  = cur_valid;
            bus.mem_we   = !is_load_q;
            bus.mem_addr = addr_q;
            if (!is_load_q) begin
               bus.rf_read_reg = cur_idx;
               bus.mem_wdata   = bus.rf_read_data;
            end else if (bus.mem_ack && cur_valid) begin
               bus.rf_regwrite   = 1'b1;
               bus.rf_write_reg  = cur_idx;
               bus.rf_write_data = bus.mem_rdata;
            end
         end
         WB: begin
            busy = 1'b1;
            if (wb_enable) begin
               bus.rf_regwrite   = 1'b1;
               bus.rf_write_reg  = base_reg_q;
               bus.rf_write_data = final_q;
            end
         end
         DONE: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized self-checking bench for the LDM/STM sequencer with a
// transaction-level reference model (beat list, latency, final register file).
module tb_ldm_stm_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        is_load = 1'b0;
   logic        up = 1'b0;
   logic        pre = 1'b0;
   logic        writeback = 1'b0;
   logic [15:0] reg_list = '0;
   logic [3:0]  base_reg = '0;
   logic [31:0] base_addr = '0;
   logic        busy;
   logic        done;

   ldm_stm_sequencer_if #(.DATA_W(32), .REG_W(4)) bus ();

   ldm_stm_sequencer #(.DATA_W(32), .REG_W(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .is_load   (is_load),
      .up        (up),
      .pre       (pre),
      .writeback (writeback),
      .reg_list  (reg_list),
      .base_reg  (base_reg),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   always #5 clock = ~clock;

   logic [31:0] rf [16];
   logic [31:0] mem_pre [logic [31:0]];
   int          stall_plan [16];
   int          total = 0;
   int          bad = 0;

   assign bus.rf_read_data = rf[bus.rf_read_reg];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_pre.exists(a)) return mem_pre[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic run_xfer(input bit ld, input bit u, input bit p, input bit wbk,
                           input logic [15:0] list, input logic [3:0] breg,
                           input logic [31:0] base, input bit junk, input string name);
      logic [31:0] orig_rf [16];
      logic [31:0] want_rf [16];
      logic [31:0] want_addr [$];
      int          want_reg [$];
      logic [31:0] lo, fin, span;
      logic [3:0]  pend_reg;
      logic [31:0] pend_data;
      bit          pend, got_done;
      int          n, lat, stalls, beat, wr_cnt, want_wr, stall_left, cyc;

      n    = $countones(list);
      span = 32'(4 * n);
      lo   = u ? (p ? base + 32'd4 : base) : (p ? base - span : base - span + 32'd4);
      fin  = u ? base + span : base - span;
      for (int i = 0; i < 16; i++) begin
         orig_rf[i] = rf[i];
         want_rf[i] = rf[i];
      end
      for (int r = 0; r < 16; r++) begin
         if (list[r]) begin
            want_addr.push_back(lo + 32'(4 * want_reg.size()));
            want_reg.push_back(r);
         end
      end
      stalls = 0;
      for (int k = 0; k < n; k++) stalls += stall_plan[k];
      if (ld) begin
         for (int k = 0; k < n; k++) want_rf[want_reg[k]] = mem_word(want_addr[k]);
      end
      want_wr = ld ? n : 0;
      if (n > 0 && wbk && !(ld && list[breg])) begin
         want_rf[breg] = fin;
         want_wr++;
      end
      lat = (n == 0) ? 2 : 3 + n + stalls;

      @(negedge clock);
      start = 1'b1; is_load = ld; up = u; pre = p; writeback = wbk;
      reg_list = list; base_reg = breg; base_addr = base;

      beat = 0; wr_cnt = 0; pend = 1'b0; got_done = 1'b0;
      stall_left = stall_plan[0];
      cyc = 0;
      while (!got_done && cyc < lat + 20) begin
         cyc++;
         @(posedge clock); #1;
         if (pend) begin rf[pend_reg] = pend_data; pend = 1'b0; end
         @(negedge clock);
         if (junk) begin
            start = ($urandom_range(0, 2) == 0); is_load = 1'($urandom); up = 1'($urandom);
            pre = 1'($urandom); writeback = 1'($urandom); reg_list = 16'($urandom);
            base_reg = 4'($urandom); base_addr = $urandom;
         end else begin
            start = 1'b0;
         end
         if (bus.mem_req) begin
            bus.mem_rdata = mem_word(bus.mem_addr);
            if (stall_left > 0) begin bus.mem_ack = 1'b0; stall_left--; end
            else bus.mem_ack = 1'b1;
         end else begin
            bus.mem_ack = 1'($urandom);
            bus.mem_rdata = $urandom;
         end
         #1;
         check({name, ".done"}, done, (cyc == lat));
         check({name, ".busy"}, busy, (cyc < lat));
         if (bus.mem_req) begin
            if (beat < n) begin
               check({name, ".addr"}, bus.mem_addr, want_addr[beat]);
               check({name, ".we"}, bus.mem_we, !ld);
               if (!ld) check({name, ".wdata"}, bus.mem_wdata, orig_rf[want_reg[beat]]);
            end else begin
               check({name, ".extra_req"}, 32'(beat), 32'(n - 1));
            end
            if (bus.mem_ack) begin
               beat++;
               stall_left = (beat < 16) ? stall_plan[beat] : 0;
            end
         end
         if (bus.rf_regwrite) begin
            wr_cnt++;
            pend = 1'b1; pend_reg = bus.rf_write_reg; pend_data = bus.rf_write_data;
         end
         if (done) got_done = 1'b1;
      end
      if (pend) rf[pend_reg] = pend_data;
      check({name, ".got_done"}, got_done, 1'b1);
      check({name, ".beats"}, 32'(beat), 32'(n));
      check({name, ".rf_writes"}, 32'(wr_cnt), 32'(want_wr));
      for (int i = 0; i < 16; i++) check($sformatf("%s.r%0d", name, i), rf[i], want_rf[i]);
      $display("txn %s: %s up=%0d pre=%0d wb=%0d list=%04h base_reg=%0d base=%08h n=%0d latency=%0d",
               name, ld ? "LDM" : "STM", u, p, wbk, list, breg, base, n, lat);
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".busy"}, busy, 1'b0);
      check({name, ".done"}, done, 1'b0);
      check({name, ".mem_req"}, bus.mem_req, 1'b0);
      check({name, ".mem_we"}, bus.mem_we, 1'b0);
      check({name, ".mem_addr"}, bus.mem_addr, 32'h0);
      check({name, ".mem_wdata"}, bus.mem_wdata, 32'h0);
      check({name, ".rf_regwrite"}, bus.rf_regwrite, 1'b0);
      check({name, ".rf_write_reg"}, 32'(bus.rf_write_reg), 32'h0);
      check({name, ".rf_write_data"}, bus.rf_write_data, 32'h0);
      check({name, ".rf_read_reg"}, 32'(bus.rf_read_reg), 32'h0);
   endtask

   task automatic run_reset_abort();
      logic [31:0] snap [16];
      @(negedge clock);
      start = 1'b0; bus.mem_ack = 1'b0;
      for (int i = 0; i < 16; i++) snap[i] = rf[i];
      @(negedge clock);
      start = 1'b1; is_load = 1'b1; up = 1'b1; pre = 1'b0; writeback = 1'b1;
      reg_list = 16'h00F0; base_reg = 4'd1; base_addr = 32'h0000_3000;
      @(negedge clock);                       // SETUP
      start = 1'b0;
      @(negedge clock);                       // beat 1 at 0x3000
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBEEF_0004;
      #1;
      check("rst.beat1_we", bus.rf_regwrite, 1'b1);
      check("rst.beat1_reg", 32'(bus.rf_write_reg), 32'd4);
      check("rst.beat1_addr", bus.mem_addr, 32'h0000_3000);
      @(posedge clock); #1;
      rf[4] = 32'hBEEF_0004;
      @(negedge clock);                       // beat 2: abort here
      reset = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBEEF_0005;
      #1;
      check_all_zero("rst.abort");
      for (int c = 0; c < 3; c++) begin
         @(negedge clock); #1;
         check("rst.hold_rfwe", bus.rf_regwrite, 1'b0);
         check("rst.hold_done", done, 1'b0);
      end
      @(negedge clock);
      reset = 1'b1; bus.mem_ack = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock); #1;
         check("rst.after_req", bus.mem_req, 1'b0);
         check("rst.after_rfwe", bus.rf_regwrite, 1'b0);
         check("rst.after_done", done, 1'b0);
         check("rst.after_busy", busy, 1'b0);
      end
      for (int i = 5; i < 8; i++) check($sformatf("rst.r%0d_kept", i), rf[i], snap[i]);
      check("rst.base_kept", rf[1], snap[1]);
      $display("txn reset_abort: LDM list=00F0 aborted during beat 2");
   endtask

   task automatic run_random(input int count);
      logic [15:0] l;
      logic [31:0] b;
      for (int t = 0; t < count; t++) begin
         case ($urandom_range(0, 4))
            0:       l = 16'h0000;
            1:       l = 16'(1 << $urandom_range(0, 15));
            2:       l = 16'hFFFF;
            default: l = 16'($urandom);
         endcase
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         for (int k = 0; k < 16; k++) stall_plan[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         run_xfer(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), l,
                  4'($urandom), b, 1'($urandom), $sformatf("rnd%0d", t));
      end
   endtask

   initial begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      for (int k = 0; k < 16; k++) stall_plan[k] = 0;

      repeat (2) @(negedge clock);
      #1;
      check_all_zero("reset");
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_all_zero("idle");

      // STM IA, r1/r3, writeback into r13.
      rf[1] = 32'h11; rf[3] = 32'h33;
      run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 16'h000A, 4'd13, 32'h0000_1000, 1'b0, "stm_ia");
      check("stm_ia.base_final", rf[13], 32'h0000_1008);

      // LDM DB, r0/r2/r7.
      mem_pre[32'h0000_1FF4] = 32'hA0;
      mem_pre[32'h0000_1FF8] = 32'hA2;
      mem_pre[32'h0000_1FFC] = 32'hA7;
      run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 16'h0085, 4'd9, 32'h0000_2000, 1'b0, "ldm_db");
      check("ldm_db.r7", rf[7], 32'hA7);
      check("ldm_db.base_final", rf[9], 32'h0000_1FF4);

      // LDM IB with base in the list: loaded value wins.
      mem_pre[32'h0000_4004] = 32'h0000_DEAD;
      run_xfer(1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 4'd4, 32'h0000_4000, 1'b0, "ldm_ib_base");
      check("ldm_ib_base.r4", rf[4], 32'h0000_DEAD);

      // Empty list.
      run_xfer(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd2, 32'h0000_5000, 1'b0, "empty");

      // STM with base in list stores original base; DA mode.
      run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 16'h0106, 4'd2, 32'h0000_6000, 1'b0, "stm_da_base");

      // Three-register STM with a 3-cycle stall on beat 2 and stray starts.
      stall_plan[1] = 3;
      run_xfer(1'b0, 1'b1, 1'b0, 1'b0, 16'h0124, 4'd0, 32'h0000_7000, 1'b1, "stm_stall");
      stall_plan[1] = 0;

      run_reset_abort();
      run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 16'h00F0, 4'd1, 32'h0000_3000, 1'b0, "post_reset");

      run_random(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle controller that sequences the register file and the memory port for block-transfer instructions (LDM/STM, all four addressing modes).
- It walks a 16-bit register list from lowest to highest register, one register per beat.
  - For a store (STM), it reads the register through a register-file read port and writes the value to memory.
  - For a load (LDM), it writes the memory data into the register file.
- Optional base writeback happens at the end.
- It sits between the decode/execute control and the register file, and owns the register-file port while busy.

Parameters:
- DATA_W, 32, data and address width.
- REG_W, 4, register number width (16 registers).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a transfer; ignored while busy=1.
- is_load  in  1  1=LDM, 0=STM; sampled with start.
- up  in  1  1=increment, 0=decrement; sampled with start.
- pre  in  1  1=pre-index (IB/DB), 0=post (IA/DA); sampled with start.
- writeback  in  1  update base register at end; sampled with start.
- reg_list  in  16  bit i = transfer register i; sampled with start.
- base_reg  in  REG_W  base register number; sampled with start.
- base_addr  in  DATA_W  current base register value; sampled with start.
- busy  out  1  high from the cycle after start until the cycle done is asserted.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write (STM).
- mem_addr  out  DATA_W  word address of the current beat.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  memory accepts/completes the beat this cycle.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- rf_read_reg  out  REG_W  register-file read select (STM data, combinational read).
- rf_read_data  in  DATA_W  register-file read data.
- rf_write_reg  out  REG_W  register-file write select.
- rf_write_data  out  DATA_W  register-file write data.
- rf_regwrite  out  1  register-file write enable.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: busy, done, mem_req, mem_we, mem_addr, mem_wdata, rf_regwrite, rf_write_reg, rf_write_data, rf_read_reg.
  - Reset asserted mid-transfer aborts it: no further beats, no writeback, no done.
- IDLE:
  - start=1 latches all inputs and moves to SETUP.
- SETUP (1 cycle):
  - N = popcount(reg_list).
  - Start address:
    - IA: base
    - IB: base+4
    - DA: base−4N+4
    - DB: base−4N
  - Final base: up ? base+4N : base−4N.
  - All arithmetic is modulo 2^DATA_W.
  - If N=0, go straight to DONE: no memory beats, no writeback.
  - Otherwise go to XFER.
- XFER:
  - cur = lowest set bit of the remaining list.
  - mem_req=1, mem_addr=current address, mem_we=!is_load.
  - STM: rf_read_reg=cur; mem_wdata=rf_read_data, combinational in the same cycle.
  - While mem_ack=0, hold all outputs stable.
  - On mem_ack=1:
    - If LDM: rf_regwrite=1, rf_write_reg=cur, rf_write_data=mem_rdata in that same cycle.
    - Clear bit cur and advance the address by +4. Addresses always ascend.
    - If bits remain, stay in XFER; mem_req stays high and the next beat's address appears the next cycle.
    - If no bits remain, go to WB.
- WB (1 cycle):
  - Writeback is suppressed if is_load=1 and reg_list[base_reg]=1; the loaded value wins.
  - Otherwise, if writeback=1: rf_regwrite=1, rf_write_reg=base_reg, rf_write_data=final base.
  - STM with base in the list stores the original base value, because the base is written only in WB.
  - Go to DONE.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - A start in the DONE cycle is ignored.
- Latency: 2 + N + (cycles of mem_ack stall) + 1 cycles from start to done for N>0; 2 cycles for N=0.
- rf_regwrite is never asserted outside an LDM ack beat or the WB cycle.

Decomposition:
- Shared package arm_pkg holds:
  - state enum (IDLE, SETUP, XFER, WB, DONE)
  - REG_W and DATA_W
  - constants WORD_BYTES=4 and NUM_REGS=16
- One natural sub-module, reg_list_scan: 16-bit priority encoder (lowest set bit, valid flag) plus popcount.
  - Purely combinational and reusable.

Test Plan:
- STM IA: base=0x1000, list=0x000A (r1,r3), r1=0x11, r3=0x33, writeback=1, mem_ack always 1 -> writes 0x11@0x1000 and 0x33@0x1004; r_base=0x1008 in WB; done 5 cycles after start.
- LDM DB: base=0x2000, list=0x0085 (r0,r2,r7), mem_rdata=0xA0,0xA2,0xA7 -> addresses 0x1FF4, 0x1FF8, 0x1FFC; r0=0xA0, r2=0xA2, r7=0xA7; with writeback=1, base becomes 0x1FF4.
- LDM IB with base_reg=r4 in list=0x0010, writeback=1, rdata=0xDEAD -> address base+4; r4=0xDEAD; no WB write.
- Empty list=0x0000, start -> no mem_req, no rf_regwrite, done pulses 2 cycles after start.
- mem_ack stalls of 3 cycles on beat 2 of a 3-register STM -> mem_addr/mem_wdata held stable during the stall; total latency grows by 3; start pulsed mid-transfer is ignored.
- reset=0 asserted during beat 2 of an LDM -> outputs 0 immediately; no further rf_regwrite; no done; new start after release works normally.
